line_fill_unit: RTL
===================

Name: line_fill_unit

Overview:
- Fetches one 4-word cache line from main memory on a cache miss and presents it as the cache's `dataIn[0:3]` line bus.
- Sits directly downstream of the direct-mapped cache (consumes the miss address) and upstream of its line-data input.
- Talks to main memory through a single-word request/acknowledge handshake.
- Assembles the line in an internal buffer and counts completed fills.

Parameters:
- ADDR_W, 15, word-address width (matches cache address).
- DATA_W, 32, word width.
- WORDS, 4, words per line; power of two; line base = address with low log2(WORDS) bits cleared.
- CNT_W, 15, width of fill counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  cache requests a line fill.
- req_addr  input  ADDR_W  miss word address; any word within the line.
- req_ready  output  1  unit can accept a request (IDLE only).
- mem_req  output  1  word read request to main memory.
- mem_addr  output  ADDR_W  word address being read.
- mem_ack  input  1  memory returns mem_rdata this cycle.
- mem_rdata  input  DATA_W  read word, valid when mem_ack=1.
- line_valid  output  1  one-cycle pulse: line_data/line_addr hold a complete new line.
- line_addr  output  ADDR_W  base (aligned) address of the line in line_data.
- line_data  output  DATA_W x [0:WORDS-1]  unpacked line buffer, index = word offset.
- busy  output  1  fill in progress (not IDLE).
- fill_count  output  CNT_W  number of completed fills, saturating.

Behaviour:
- Reset (rst=0, async): state IDLE; req_ready=1, mem_req=0, mem_addr=0, line_valid=0, busy=0, line_addr=0, all line_data words=0, fill_count=0, word index=0. A reset mid-fill aborts it; mem_req drops immediately, not at the next edge.
- States: IDLE, FETCH, DONE.
- IDLE: req_ready=1, busy=0.
  - On an edge with req_valid=1: latch base = {req_addr[ADDR_W-1:log2(WORDS)], 0}, clear index, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: req_ready=0, busy=1, mem_req=1, mem_addr=base+index (registered, stable until ack).
  - On an edge with mem_ack=1: line_data[index] <= mem_rdata.
  - If index==WORDS-1, go to DONE; else index++ and mem_addr advances to the next word.
  - mem_ack=0 leaves index and address unchanged; there is no timeout.
  - Back-to-back acks fill one word per cycle.
- DONE: one cycle; line_valid=1, line_addr=base, mem_req=0, req_ready=0, busy=1.
  - fill_count++ unless at all-ones, where it saturates and holds.
  - Next state is IDLE.
- Latency: request accepted at edge E0. With mem_ack held at 1, words are captured at E1..E4 and line_valid is high between E4 and E5. Each extra cycle with mem_ack=0 adds one cycle.
- line_data and line_addr hold their values after DONE until the next fill overwrites them word by word.
  - A partially written buffer is never flagged valid.
- mem_ack outside FETCH is ignored; no capture, no state change.
- req_valid outside IDLE is ignored; the requester must hold it until it sees req_ready=1.
  - A request arriving in the DONE cycle is accepted on the following IDLE edge, giving a minimum 1-cycle gap between fills.
- Line-aligned addressing means base+index never crosses a line boundary. Top line 0x7FFC..0x7FFF fetches without wrap.
- Arithmetic is unsigned. Index width is log2(WORDS). Counter increment uses CNT_W bits with saturation.

Test Plan:
- Reset then idle: rst=0 mid-cycle -> all outputs at reset values immediately; req_ready=1, fill_count=0.
- Single fill, zero wait: req_addr=0x1235, mem_ack=1 always, mem_rdata=0xA0+mem_addr[1:0] -> mem_addr 0x1234,0x1235,0x1236,0x1237 on consecutive cycles; line_valid pulse 1 cycle; line_addr=0x1234; line_data={0xA0,0xA1,0xA2,0xA3}; fill_count=1.
- Wait states: mem_ack=0 for 3 cycles before each word -> mem_addr stable while waiting; line_valid 12 cycles later than the zero-wait case; data correct.
- Request during fill: req_valid pulses while busy -> ignored; req_ready=0; one fill only; fill_count increments by 1.
- Reset mid-fill: rst=0 after 2 words captured -> mem_req=0 immediately, no line_valid, line_data all zero; a new request afterwards completes normally.
- Top line and saturation: req_addr=0x7FFE -> mem_addr 0x7FFC..0x7FFF, no wrap. With CNT_W=2, 5 fills -> fill_count 1,2,3,3,3.

Source files
------------

// File: rtl/line_fill_unit.sv
// line_fill_unit: fetches one WORDS-word cache line from main memory on a miss.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   req_valid, req_addr  line fill request from the cache (any word inside the line)
//   req_ready            high only in IDLE; requests are accepted on that edge
//   mem_req, mem_addr    single-word read request to main memory (held until mem_ack)
//   mem_ack, mem_rdata   memory returns one word in the cycle mem_ack is high
//   line_valid           one-cycle pulse when line_addr/line_data hold a new complete line
//   line_addr            aligned base address of the line in line_data
//   line_data            line buffer, index = word offset inside the line
//   busy                 a fill is in progress (not IDLE)
//   fill_count           number of completed fills, saturating at all-ones
module line_fill_unit #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned CNT_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              line_valid,
  output logic [ADDR_W-1:0] line_addr,
  output logic [DATA_W-1:0] line_data [0:WORDS-1],
  output logic              busy,
  output logic [CNT_W-1:0]  fill_count
);

  localparam int unsigned IdxW = $clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] OffsMask = ADDR_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDone
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   req_base;

  // Clear the word offset so the fetch always starts at the line boundary.
  assign req_base = req_addr & ~OffsMask;

  // All outputs are registered; the async reset clears mem_req without waiting for an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      base_q     <= '0;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      line_valid <= 1'b0;
      line_addr  <= '0;
      busy       <= 1'b0;
      fill_count <= '0;
      for (int i = 0; i < WORDS; i++) begin
        line_data[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            base_q    <= req_base;
            idx_q     <= '0;
            mem_addr  <= req_base;
            mem_req   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StFetch;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            line_data[idx_q] <= mem_rdata;
            if (idx_q == LastIdx) begin
              mem_req    <= 1'b0;
              line_valid <= 1'b1;
              line_addr  <= base_q;
              if (fill_count != CntMax) begin
                fill_count <= fill_count + 1'b1;
              end
              state_q    <= StDone;
            end else begin
              idx_q    <= idx_q + 1'b1;
              // Line-aligned base: base + offset never carries out of the line.
              mem_addr <= base_q + ADDR_W'(idx_q) + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          line_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
